// File: rtl/band_scale_sched.sv
// band_scale_sched
// ----------------
// Time-multiplexes one shared POT-squared band scaler across NUM_BANDS
// equalizer band outputs and a final master-volume stage.
//
// On a smpl_vld strobe (while idle) all band samples, band POTs and the
// volume POT are snapshotted. The snapshot is then walked through the
// external scaler one band per cycle (BAND). The scaled results are summed
// in a wide accumulator that cannot overflow. The sum is saturated to 16
// bits and scaled once more by the volume POT (VOL). eq_out is updated with
// a one-cycle eq_vld pulse.
//
// Optional feature (macro BAND_SCALE_SCHED_OVRN_CNT_EN):
//   ovrn_clr input and ovrn_cnt[7:0] output. The counter is a saturating
//   count of strobes dropped because a sample was still in flight.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   smpl_vld   in   one-cycle strobe, new band samples ready
//   bands      in   16*NUM_BANDS signed band samples, band k at [16k+15:16k]
//   pots       in   12*NUM_BANDS unsigned band POTs, band k at [12k+11:12k]
//   vol_pot    in   12-bit unsigned master volume POT
//   scl_pot    out  POT driven to the shared scaler
//   scl_audio  out  signed audio driven to the shared scaler
//   scl_result in   signed combinational result from the shared scaler
//   eq_out     out  equalized, volume-scaled sample (held between pulses)
//   eq_vld     out  one-cycle pulse, eq_out updated
//   busy       out  high while a sample is in progress
//   dbg_state  out  current FSM state (IDLE=0, BAND=1, VOL=2)
//   ovrn_clr   in   (optional) synchronous clear of ovrn_cnt
//   ovrn_cnt   out  (optional) saturating dropped-strobe count
//
// Handshake: smpl_vld carries no ready. A strobe is accepted only when
// busy is low; a strobe seen while busy is high is dropped and leaves the
// in-flight snapshot untouched.

module band_scale_sched #(
    parameter int NUM_BANDS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      smpl_vld,
    input  logic [16*NUM_BANDS-1:0]   bands,
    input  logic [12*NUM_BANDS-1:0]   pots,
    input  logic [11:0]               vol_pot,
    output logic [11:0]               scl_pot,
    output logic [15:0]               scl_audio,
    input  logic [15:0]               scl_result,
    output logic [15:0]               eq_out,
    output logic                      eq_vld,
    output logic                      busy,
    output logic [1:0]                dbg_state
`ifdef BAND_SCALE_SCHED_OVRN_CNT_EN
    ,
    input  logic                      ovrn_clr,
    output logic [7:0]                ovrn_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_BANDS);
    // One extra bit beyond log2(NUM_BANDS) growth keeps the sign intact.
    localparam int ACC_W = 16 + $clog2(NUM_BANDS) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32768);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BAND = 2'd1,
        VOL  = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic signed [ACC_W-1:0]             acc_q, acc_d;
    logic [NUM_BANDS-1:0][15:0]          bands_q, bands_d;
    logic [NUM_BANDS-1:0][11:0]          pots_q, pots_d;
    logic [11:0]                         vol_q, vol_d;
    logic [15:0]                         eq_out_q, eq_out_d;
    logic                                eq_vld_q, eq_vld_d;
    logic [15:0]                         acc_sat;
    logic signed [ACC_W-1:0]             result_ext;

    // Saturate the accumulated sum to the 16-bit audio range.
    always_comb begin
        acc_sat = acc_q[15:0];
        if (acc_q > ACC_MAX) begin
            acc_sat = 16'h7FFF;
        end else if (acc_q < ACC_MIN) begin
            acc_sat = 16'h8000;
        end
    end

    assign result_ext = {{(ACC_W-16){scl_result[15]}}, scl_result};

    // Next state. Scaler drive depends on registered state only.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        bands_d   = bands_q;
        pots_d    = pots_q;
        vol_d     = vol_q;
        eq_out_d  = eq_out_q;
        eq_vld_d  = 1'b0;
        scl_pot   = 12'd0;
        scl_audio = 16'd0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                if (smpl_vld) begin
                    bands_d = bands;
                    pots_d  = pots;
                    vol_d   = vol_pot;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = BAND;
                end
            end
            BAND: begin
                busy      = 1'b1;
                scl_pot   = pots_q[idx_q];
                scl_audio = bands_q[idx_q];
                acc_d     = acc_q + result_ext;
                idx_d     = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = VOL;
                end
            end
            VOL: begin
                busy      = 1'b1;
                scl_pot   = vol_q;
                scl_audio = acc_sat;
                eq_out_d  = scl_result;
                eq_vld_d  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            bands_q  <= '0;
            pots_q   <= '0;
            vol_q    <= '0;
            eq_out_q <= '0;
            eq_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            bands_q  <= bands_d;
            pots_q   <= pots_d;
            vol_q    <= vol_d;
            eq_out_q <= eq_out_d;
            eq_vld_q <= eq_vld_d;
        end
    end

    assign eq_out    = eq_out_q;
    assign eq_vld    = eq_vld_q;
    assign dbg_state = state_q;

`ifdef BAND_SCALE_SCHED_OVRN_CNT_EN
    logic [7:0] ovrn_q, ovrn_d;

    // Clear wins over a same-cycle drop; the count sticks at 0xFF.
    always_comb begin
        ovrn_d = ovrn_q;
        if (ovrn_clr) begin
            ovrn_d = 8'd0;
        end else if (busy && smpl_vld && (ovrn_q != 8'hFF)) begin
            ovrn_d = ovrn_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovrn_q <= 8'd0;
        end else begin
            ovrn_q <= ovrn_d;
        end
    end

    assign ovrn_cnt = ovrn_q;
`endif

endmodule
